// File: rtl/tennis_pkg.sv
// Shared types and constants for the tennis match sequencer.
package tennis_pkg;

  localparam int unsigned SCORE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    RALLY,
    PAUSE,
    GAME_OVER
  } match_state_t;

  typedef enum logic {
    LEFT,
    RIGHT
  } side_t;

  function automatic side_t other_side(input side_t s);
    return (s == LEFT) ? RIGHT : LEFT;
  endfunction

endpackage

// File: rtl/tennis_match_ctrl_if.sv
// Button/datapath strobes in, serve gating and score display out.
interface tennis_match_ctrl_if;
  import tennis_pkg::*;

  logic               move_tick;
  logic               toss;
  logic               point_left;
  logic               point_right;
  logic               serve_en;
  logic               serve_pulse;
  logic               server_right;
  logic               blank;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               game_over;
  logic               winner_right;

  modport master (
    output move_tick, toss, point_left, point_right,
    input  serve_en, serve_pulse, server_right, blank,
    input  score_left, score_right, game_over, winner_right
  );

  modport slave (
    input  move_tick, toss, point_left, point_right,
    output serve_en, serve_pulse, server_right, blank,
    output score_left, score_right, game_over, winner_right
  );

endinterface

// File: rtl/tennis_score_keeper.sv
// Score registers with deuce collapse; flags a match win on the awarding update.
module tennis_score_keeper
  import tennis_pkg::*;
#(
  parameter int unsigned WIN_POINTS = 7
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_award_valid,
  input  side_t              i_award_side,
  input  logic               i_clear,
  output logic [SCORE_W-1:0] o_score_left,
  output logic [SCORE_W-1:0] o_score_right,
  output logic               o_win,
  output side_t              o_win_side
);

  localparam logic [SCORE_W-1:0] DEUCE_PT = SCORE_W'(WIN_POINTS - 1);
  localparam logic [SCORE_W:0]   WIN_PT   = (SCORE_W + 1)'(WIN_POINTS);
  localparam logic [SCORE_W:0]   LEAD     = (SCORE_W + 1)'(2);

  logic [SCORE_W-1:0] r_left;
  logic [SCORE_W-1:0] r_right;
  logic [SCORE_W-1:0] w_next_left;
  logic [SCORE_W-1:0] w_next_right;
  logic [SCORE_W:0]   w_left_ext;
  logic [SCORE_W:0]   w_right_ext;
  logic               w_win_left;
  logic               w_win_right;

  always_comb begin
    w_next_left  = r_left;
    w_next_right = r_right;
    if (i_award_valid) begin
      if (i_award_side == LEFT) w_next_left  = r_left  + SCORE_W'(1);
      else                      w_next_right = r_right + SCORE_W'(1);
    end
    // A tie at or beyond game point folds back to WIN_POINTS-1 all.
    if ((w_next_left == w_next_right) && (w_next_left >= DEUCE_PT)) begin
      w_next_left  = DEUCE_PT;
      w_next_right = DEUCE_PT;
    end
  end

  assign w_left_ext  = {1'b0, w_next_left};
  assign w_right_ext = {1'b0, w_next_right};
  assign w_win_left  = (w_left_ext  >= WIN_PT) && (w_left_ext  >= w_right_ext + LEAD);
  assign w_win_right = (w_right_ext >= WIN_PT) && (w_right_ext >= w_left_ext  + LEAD);
  assign o_win       = i_award_valid & (w_win_left | w_win_right);
  assign o_win_side  = w_win_right ? RIGHT : LEFT;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_left  <= '0;
      r_right <= '0;
    end else if (i_clear) begin
      r_left  <= '0;
      r_right <= '0;
    end else if (i_award_valid) begin
      r_left  <= w_next_left;
      r_right <= w_next_right;
    end
  end

  assign o_score_left  = r_left;
  assign o_score_right = r_right;

endmodule

// File: rtl/tennis_match_ctrl.sv
// Match sequencer: serve gating, server rotation, inter-point blanking, winner.
// Optional serve timeout enabled by defining TENNIS_SERVE_TIMEOUT_EN.
module tennis_match_ctrl
  import tennis_pkg::*;
#(
  parameter int unsigned WIN_POINTS    = 7,
  parameter int unsigned PAUSE_TICKS   = 4,
  parameter int unsigned SERVE_ROTATE  = 2,
  parameter int unsigned TIMEOUT_TICKS = 15
) (
  input logic                CLK100MHZ,
  input logic                CPU_RESETN,
  tennis_match_ctrl_if.slave bus
);

  localparam int unsigned PAUSE_W = $clog2(PAUSE_TICKS + 1);
  localparam int unsigned ROT_W   = (SERVE_ROTATE > 1) ? $clog2(SERVE_ROTATE) : 1;

  if ((WIN_POINTS < 2) || (WIN_POINTS > 14) || (PAUSE_TICKS < 1) ||
      (SERVE_ROTATE < 1) || (TIMEOUT_TICKS < 1)) begin : g_param_check
    $error("tennis_match_ctrl: parameter out of range");
  end

  match_state_t       r_state;
  logic               r_toss_d;
  side_t              r_server;
  side_t              r_first_server;
  side_t              r_winner;
  logic               r_serve_en;
  logic               r_serve_pulse;
  logic               r_blank;
  logic               r_game_over;
  logic [PAUSE_W-1:0] r_pause;
  logic [ROT_W-1:0]   r_rot;

  logic               w_toss_rise;
  logic               w_rally_end;
  logic               w_timeout;
  logic               w_point_end;
  logic               w_award_valid;
  side_t              w_award_side;
  logic               w_clear;
  logic               w_win;
  side_t              w_win_side;
  logic [SCORE_W-1:0] w_score_left;
  logic [SCORE_W-1:0] w_score_right;

  assign w_toss_rise = bus.toss & ~r_toss_d;
  assign w_rally_end = (r_state == RALLY) & (bus.point_left | bus.point_right);

`ifdef TENNIS_SERVE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);

  logic [TMO_W-1:0] r_tmo;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)            r_tmo <= '0;
    else if (r_state != SERVE)  r_tmo <= '0;
    else if (bus.move_tick)     r_tmo <= r_tmo + TMO_W'(1);
  end

  // A toss on the expiring tick wins; the serve is taken, not forfeited.
  assign w_timeout = (r_state == SERVE) & ~w_toss_rise & bus.move_tick &
                     (r_tmo == TMO_W'(TIMEOUT_TICKS - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_award_valid = 1'b0;
    w_award_side  = LEFT;
    if (w_timeout) begin
      w_award_valid = 1'b1;
      w_award_side  = other_side(r_server);
    end else if (w_rally_end && !(bus.point_left && bus.point_right)) begin
      w_award_valid = 1'b1;
      w_award_side  = bus.point_left ? RIGHT : LEFT;
    end
  end

  assign w_point_end = w_rally_end | w_timeout;
  assign w_clear     = (r_state == GAME_OVER) & w_toss_rise;

  tennis_score_keeper #(
    .WIN_POINTS (WIN_POINTS)
  ) u_score (
    .i_clk         (CLK100MHZ),
    .i_rst_n       (CPU_RESETN),
    .i_award_valid (w_award_valid),
    .i_award_side  (w_award_side),
    .i_clear       (w_clear),
    .o_score_left  (w_score_left),
    .o_score_right (w_score_right),
    .o_win         (w_win),
    .o_win_side    (w_win_side)
  );

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)             r_pause <= '0;
    else if (r_state != PAUSE)   r_pause <= '0;
    else if (bus.move_tick)      r_pause <= r_pause + PAUSE_W'(1);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state        <= IDLE;
      r_toss_d       <= 1'b0;
      r_server       <= LEFT;
      r_first_server <= LEFT;
      r_winner       <= LEFT;
      r_serve_en     <= 1'b0;
      r_serve_pulse  <= 1'b0;
      r_blank        <= 1'b1;
      r_game_over    <= 1'b0;
      r_rot          <= '0;
    end else begin
      r_toss_d      <= bus.toss;
      r_serve_pulse <= 1'b0;
      if (w_point_end) begin
        r_serve_en <= 1'b0;
        r_blank    <= 1'b1;
        if (w_win) begin
          r_state     <= GAME_OVER;
          r_game_over <= 1'b1;
          r_winner    <= w_win_side;
        end else begin
          r_state <= PAUSE;
          // Lets leave the rotation count untouched.
          if (w_award_valid) begin
            if (r_rot == ROT_W'(SERVE_ROTATE - 1)) begin
              r_rot    <= '0;
              r_server <= other_side(r_server);
            end else begin
              r_rot <= r_rot + ROT_W'(1);
            end
          end
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_toss_rise) begin
              r_state    <= SERVE;
              r_serve_en <= 1'b1;
              r_blank    <= 1'b0;
            end
          end
          SERVE: begin
            if (w_toss_rise) begin
              r_state       <= RALLY;
              r_serve_en    <= 1'b0;
              r_serve_pulse <= 1'b1;
            end
          end
          PAUSE: begin
            if (bus.move_tick && (r_pause == PAUSE_W'(PAUSE_TICKS - 1))) begin
              r_state    <= SERVE;
              r_serve_en <= 1'b1;
              r_blank    <= 1'b0;
            end
          end
          GAME_OVER: begin
            if (w_toss_rise) begin
              r_state        <= SERVE;
              r_serve_en     <= 1'b1;
              r_blank        <= 1'b0;
              r_game_over    <= 1'b0;
              r_rot          <= '0;
              r_server       <= other_side(r_first_server);
              r_first_server <= other_side(r_first_server);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.serve_en     = r_serve_en;
  assign bus.serve_pulse  = r_serve_pulse;
  assign bus.server_right = (r_server == RIGHT);
  assign bus.blank        = r_blank;
  assign bus.score_left   = w_score_left;
  assign bus.score_right  = w_score_right;
  assign bus.game_over    = r_game_over;
  assign bus.winner_right = (r_winner == RIGHT);

endmodule

// File: tb/tb_tennis_match_ctrl.sv
// Directed bench for tennis_match_ctrl (serve timeout scenario when TENNIS_SERVE_TIMEOUT_EN is defined).
module tb_tennis_match_ctrl;

  localparam int unsigned PAUSE_T = 4;

  logic clk;
  logic rst_n;
  int   assertions;
  int   failures;

  tennis_match_ctrl_if bus ();

  tennis_match_ctrl #(
    .WIN_POINTS    (7),
    .PAUSE_TICKS   (PAUSE_T),
    .SERVE_ROTATE  (2),
    .TIMEOUT_TICKS (15)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_toss();
    bus.toss = 1'b1;
    cyc();
    bus.toss = 1'b0;
    cyc();
  endtask

  task automatic do_tick();
    bus.move_tick = 1'b1;
    cyc();
    bus.move_tick = 1'b0;
  endtask

  task automatic do_point(input logic l, input logic r);
    bus.point_left  = l;
    bus.point_right = r;
    cyc();
    bus.point_left  = 1'b0;
    bus.point_right = 1'b0;
  endtask

  task automatic play_point(input logic l, input logic r);
    do_toss();
    do_point(l, r);
    repeat (PAUSE_T) do_tick();
  endtask

  task automatic test_reset();
    assertions++; if (bus.blank !== 1'b1) begin failures++; $display("FAIL reset_blank: got %0b expected 1", bus.blank); end
    assertions++; if (bus.serve_en !== 1'b0) begin failures++; $display("FAIL reset_serve_en: got %0b expected 0", bus.serve_en); end
    assertions++; if (bus.serve_pulse !== 1'b0) begin failures++; $display("FAIL reset_serve_pulse: got %0b expected 0", bus.serve_pulse); end
    assertions++; if (bus.game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over: got %0b expected 0", bus.game_over); end
    assertions++; if (bus.server_right !== 1'b0) begin failures++; $display("FAIL reset_server: got %0b expected 0", bus.server_right); end
    assertions++; if ({bus.score_left, bus.score_right} !== 8'h00) begin failures++; $display("FAIL reset_scores: got %0d-%0d expected 0-0", bus.score_left, bus.score_right); end
  endtask

  task automatic test_first_point();
    do_toss();
    assertions++; if (bus.serve_en !== 1'b1 || bus.blank !== 1'b0) begin failures++; $display("FAIL serve_entry: got serve_en=%0b blank=%0b expected 1/0", bus.serve_en, bus.blank); end
    bus.toss = 1'b1;
    cyc();
    assertions++; if (bus.serve_pulse !== 1'b1 || bus.serve_en !== 1'b0) begin failures++; $display("FAIL serve_pulse: got pulse=%0b serve_en=%0b expected 1/0", bus.serve_pulse, bus.serve_en); end
    bus.toss = 1'b0;
    cyc();
    assertions++; if (bus.serve_pulse !== 1'b0) begin failures++; $display("FAIL serve_pulse_one_cycle: got %0b expected 0", bus.serve_pulse); end
    bus.move_tick = 1'b1;
    do_point(1'b0, 1'b1);
    bus.move_tick = 1'b0;
    assertions++; if (bus.score_left !== 4'd1 || bus.score_right !== 4'd0) begin failures++; $display("FAIL first_point_score: got %0d-%0d expected 1-0", bus.score_left, bus.score_right); end
    assertions++; if (bus.blank !== 1'b1) begin failures++; $display("FAIL first_point_blank: got %0b expected 1", bus.blank); end
    repeat (PAUSE_T - 1) do_tick();
    assertions++; if (bus.serve_en !== 1'b0 || bus.blank !== 1'b1) begin failures++; $display("FAIL pause_not_done: got serve_en=%0b blank=%0b expected 0/1", bus.serve_en, bus.blank); end
    do_tick();
    assertions++; if (bus.serve_en !== 1'b1 || bus.blank !== 1'b0) begin failures++; $display("FAIL pause_done: got serve_en=%0b blank=%0b expected 1/0", bus.serve_en, bus.blank); end
  endtask

  task automatic test_rotation();
    play_point(1'b1, 1'b0);
    assertions++; if (bus.server_right !== 1'b1 || bus.score_right !== 4'd1) begin failures++; $display("FAIL rotate_2: got server=%0b right=%0d expected 1/1", bus.server_right, bus.score_right); end
    play_point(1'b0, 1'b1);
    assertions++; if (bus.server_right !== 1'b1 || bus.score_left !== 4'd2) begin failures++; $display("FAIL rotate_3: got server=%0b left=%0d expected 1/2", bus.server_right, bus.score_left); end
    play_point(1'b1, 1'b0);
    assertions++; if (bus.server_right !== 1'b0 || bus.score_right !== 4'd2) begin failures++; $display("FAIL rotate_4: got server=%0b right=%0d expected 0/2", bus.server_right, bus.score_right); end
  endtask

  task automatic test_let_and_ignore();
    do_point(1'b1, 1'b0);
    assertions++; if (bus.score_right !== 4'd2 || bus.serve_en !== 1'b1) begin failures++; $display("FAIL serve_strobe_ignored: got right=%0d serve_en=%0b expected 2/1", bus.score_right, bus.serve_en); end
    do_toss();
    do_point(1'b1, 1'b1);
    assertions++; if (bus.score_left !== 4'd2 || bus.score_right !== 4'd2) begin failures++; $display("FAIL let_scores: got %0d-%0d expected 2-2", bus.score_left, bus.score_right); end
    assertions++; if (bus.blank !== 1'b1 || bus.serve_en !== 1'b0) begin failures++; $display("FAIL let_pause: got blank=%0b serve_en=%0b expected 1/0", bus.blank, bus.serve_en); end
    repeat (PAUSE_T) do_tick();
    do_toss();
    do_point(1'b0, 1'b1);
    assertions++; if (bus.score_left !== 4'd3 || bus.server_right !== 1'b0) begin failures++; $display("FAIL let_not_rotated: got left=%0d server=%0b expected 3/0", bus.score_left, bus.server_right); end
    do_toss();
    assertions++; if (bus.blank !== 1'b1 || bus.serve_en !== 1'b0) begin failures++; $display("FAIL pause_toss_ignored: got blank=%0b serve_en=%0b expected 1/0", bus.blank, bus.serve_en); end
    repeat (PAUSE_T - 1) do_tick();
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    #1;
    assertions++; if ({bus.score_left, bus.score_right} !== 8'h00) begin failures++; $display("FAIL async_reset_scores: got %0d-%0d expected 0-0", bus.score_left, bus.score_right); end
    assertions++; if (bus.blank !== 1'b1 || bus.serve_en !== 1'b0) begin failures++; $display("FAIL async_reset_out: got blank=%0b serve_en=%0b expected 1/0", bus.blank, bus.serve_en); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_deuce_win();
    do_toss();
    for (int i = 0; i < 5; i++) begin
      play_point(1'b0, 1'b1);
      play_point(1'b1, 1'b0);
    end
    assertions++; if (bus.score_left !== 4'd5 || bus.score_right !== 4'd5) begin failures++; $display("FAIL five_all: got %0d-%0d expected 5-5", bus.score_left, bus.score_right); end
    play_point(1'b0, 1'b1);
    play_point(1'b1, 1'b0);
    assertions++; if (bus.score_left !== 4'd6 || bus.score_right !== 4'd6) begin failures++; $display("FAIL six_all: got %0d-%0d expected 6-6", bus.score_left, bus.score_right); end
    play_point(1'b1, 1'b0);
    assertions++; if (bus.score_right !== 4'd7 || bus.game_over !== 1'b0) begin failures++; $display("FAIL adv_right: got right=%0d over=%0b expected 7/0", bus.score_right, bus.game_over); end
    play_point(1'b0, 1'b1);
    assertions++; if (bus.score_left !== 4'd6 || bus.score_right !== 4'd6) begin failures++; $display("FAIL deuce_collapse: got %0d-%0d expected 6-6", bus.score_left, bus.score_right); end
    play_point(1'b0, 1'b1);
    assertions++; if (bus.score_left !== 4'd7 || bus.game_over !== 1'b0) begin failures++; $display("FAIL adv_left: got left=%0d over=%0b expected 7/0", bus.score_left, bus.game_over); end
    do_toss();
    do_point(1'b0, 1'b1);
    assertions++; if (bus.score_left !== 4'd8 || bus.game_over !== 1'b1 || bus.winner_right !== 1'b0) begin failures++; $display("FAIL left_wins: got left=%0d over=%0b winner_right=%0b expected 8/1/0", bus.score_left, bus.game_over, bus.winner_right); end
    assertions++; if (bus.blank !== 1'b1 || bus.serve_en !== 1'b0) begin failures++; $display("FAIL game_over_out: got blank=%0b serve_en=%0b expected 1/0", bus.blank, bus.serve_en); end
    repeat (PAUSE_T) do_tick();
    assertions++; if (bus.game_over !== 1'b1 || bus.score_left !== 4'd8) begin failures++; $display("FAIL game_over_held: got over=%0b left=%0d expected 1/8", bus.game_over, bus.score_left); end
  endtask

  task automatic test_new_match();
    bus.toss = 1'b1;
    cyc();
    assertions++; if (bus.serve_en !== 1'b1 || bus.blank !== 1'b0 || bus.game_over !== 1'b0) begin failures++; $display("FAIL new_match_out: got serve_en=%0b blank=%0b over=%0b expected 1/0/0", bus.serve_en, bus.blank, bus.game_over); end
    assertions++; if ({bus.score_left, bus.score_right} !== 8'h00 || bus.server_right !== 1'b1) begin failures++; $display("FAIL new_match_state: got %0d-%0d server=%0b expected 0-0/1", bus.score_left, bus.score_right, bus.server_right); end
    cyc();
    cyc();
    assertions++; if (bus.serve_pulse !== 1'b0 || bus.serve_en !== 1'b1) begin failures++; $display("FAIL toss_hold: got pulse=%0b serve_en=%0b expected 0/1", bus.serve_pulse, bus.serve_en); end
    bus.toss = 1'b0;
    cyc();
    play_point(1'b0, 1'b1);
    assertions++; if (bus.server_right !== 1'b1 || bus.score_left !== 4'd1) begin failures++; $display("FAIL new_match_rot1: got server=%0b left=%0d expected 1/1", bus.server_right, bus.score_left); end
    play_point(1'b0, 1'b1);
    assertions++; if (bus.server_right !== 1'b0 || bus.score_left !== 4'd2) begin failures++; $display("FAIL new_match_rot2: got server=%0b left=%0d expected 0/2", bus.server_right, bus.score_left); end
  endtask

`ifdef TENNIS_SERVE_TIMEOUT_EN
  task automatic test_timeout();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    do_toss();
    repeat (14) do_tick();
    assertions++; if (bus.serve_en !== 1'b1 || bus.score_right !== 4'd0) begin failures++; $display("FAIL timeout_early: got serve_en=%0b right=%0d expected 1/0", bus.serve_en, bus.score_right); end
    do_tick();
    assertions++; if (bus.score_right !== 4'd1 || bus.score_left !== 4'd0 || bus.blank !== 1'b1) begin failures++; $display("FAIL timeout_award: got %0d-%0d blank=%0b expected 0-1/1", bus.score_left, bus.score_right, bus.blank); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    assertions      = 0;
    failures        = 0;
    clk             = 1'b0;
    rst_n           = 1'b0;
    bus.toss        = 1'b0;
    bus.move_tick   = 1'b0;
    bus.point_left  = 1'b0;
    bus.point_right = 1'b0;
    cyc();
    cyc();
    test_reset();
    rst_n = 1'b1;
    cyc();
    test_first_point();
    test_rotation();
    test_let_and_ignore();
    test_async_reset();
    test_deuce_win();
    test_new_match();
`ifdef TENNIS_SERVE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
